// File: rtl/efpga_axil_pkg.sv
// Shared constants, types and helpers for the eFPGA AXI4-Lite register bank.
package efpga_axil_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int REG_IDX_W = 2;
    localparam int NUM_REGS = 4;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? wdata[8*b +: 8] : old[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/efpga_axil_regs.sv
// AXI4-Lite slave with four 32-bit control registers for eFPGA Core1.
// AW and W are held independently; commit waits for any pending B.
module efpga_axil_regs
    import efpga_axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [3:0]                     S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    logic                  up;
    logic                  aw_full;
    logic                  w_full;
    reg_idx_t              aw_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [3:0]            w_strb;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  commit;
    reg_idx_t              ar_idx;
    logic                  unused_bits;

    // Write channels stay closed for the first cycle out of reset
    assign S_AXI_AWREADY = up && !aw_full;
    assign S_AXI_WREADY  = up && !w_full;
    assign S_AXI_ARREADY = !S_AXI_RVALID;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_RRESP   = RESP_OKAY;

    assign commit = aw_full && w_full && !S_AXI_BVALID;
    assign ar_idx = S_AXI_ARADDR[REG_IDX_W+1:2];

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign reg_out[DATA_WIDTH*i +: DATA_WIDTH] = regs[i];
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            up           <= 1'b0;
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            aw_idx       <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            S_AXI_BVALID <= 1'b0;
            wr_pulse     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            up       <= 1'b1;
            wr_pulse <= '0;
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_full <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[REG_IDX_W+1:2];
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_full <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            // Both holds are full here, so no capture can race the clear
            if (commit) begin
                regs[aw_idx]     <= strb_merge(regs[aw_idx], w_data, w_strb);
                S_AXI_BVALID     <= 1'b1;
                aw_full          <= 1'b0;
                w_full           <= 1'b0;
                wr_pulse[aw_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
        end else begin
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                S_AXI_RDATA  <= regs[ar_idx];
                S_AXI_RVALID <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_efpga_axil_regs.sv
// Self-checking bench for efpga_axil_regs: queue-based model plus directed tests.
module tb_efpga_axil_regs;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [127:0] reg_out;
    logic [3:0]   wr_pulse;

    efpga_axil_regs dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: pending AW/W queues, register array, B/R state
    logic [31:0] m_regs [4];
    int          aw_q [$];
    logic [35:0] w_q [$];
    logic        m_b, m_rvalid, m_up;
    logic [31:0] m_rdata;
    logic [3:0]  m_pulse;
    bit          ar_hs, r_hs, aw_hs, w_hs, b_hs, cm;
    int          idx;
    logic [35:0] wd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_regs[i] = '0;
            aw_q.delete();
            w_q.delete();
            m_b = 0; m_rvalid = 0; m_up = 0; m_rdata = '0; m_pulse = '0;
        end else begin
            ar_hs = arvalid && !m_rvalid;
            r_hs  = m_rvalid && rready;
            aw_hs = m_up && awvalid && aw_q.size() == 0;
            w_hs  = m_up && wvalid && w_q.size() == 0;
            b_hs  = m_b && bready;
            cm    = aw_q.size() > 0 && w_q.size() > 0 && !m_b;
            if (r_hs) m_rvalid = 0;
            if (ar_hs) begin
                m_rdata  = m_regs[araddr[3:2]];
                m_rvalid = 1;
            end
            m_pulse = '0;
            if (b_hs) m_b = 0;
            if (cm) begin
                idx = aw_q.pop_front();
                wd  = w_q.pop_front();
                for (int b = 0; b < 4; b++)
                    if (wd[32+b]) m_regs[idx][8*b +: 8] = wd[8*b +: 8];
                m_b = 1;
                m_pulse[idx] = 1'b1;
            end
            if (aw_hs) aw_q.push_back(int'(awaddr[3:2]));
            if (w_hs) w_q.push_back({wstrb, wdata});
            m_up = 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("awready", awready, m_up && aw_q.size() == 0);
            chk("wready", wready, m_up && w_q.size() == 0);
            chk("arready", arready, !m_rvalid);
            chk("bvalid", bvalid, m_b);
            chk("bresp", bresp, 2'b00);
            chk("rvalid", rvalid, m_rvalid);
            chk("rdata", rdata, m_rdata);
            chk("rresp", rresp, 2'b00);
            chk("wr_pulse", wr_pulse, m_pulse);
            chk("reg_out", reg_out,
                {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
        end
    end

    int   pcnt [4] = '{0, 0, 0, 0};
    int   brise = 0;
    logic bprev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) if (wr_pulse[i]) pcnt[i]++;
            if (bvalid && !bprev) brise++;
            bprev = bvalid;
        end else begin
            bprev = 1'b0;
        end
    end

    task automatic aw_send(input logic [3:0] a);
        int n = 0;
        awaddr = a; awvalid = 1;
        do begin @(negedge clk); n++; end while (!awready && n < 50);
        if (!awready) chk("aw_timeout", awready, 1'b1);
        @(posedge clk); #1;
        awvalid = 0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wdata = d; wstrb = s; wvalid = 1;
        do begin @(negedge clk); n++; end while (!wready && n < 50);
        if (!wready) chk("w_timeout", wready, 1'b1);
        @(posedge clk); #1;
        wvalid = 0;
    endtask

    task automatic wait_b();
        int n = 0;
        do begin @(negedge clk); n++; end while (!bvalid && n < 50);
        if (!bvalid) chk("b_timeout", bvalid, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic ar_send(input logic [3:0] a);
        int n = 0;
        araddr = a; arvalid = 1;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        if (!arready) chk("ar_timeout", arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 0;
    endtask

    task automatic r_get(output logic [31:0] d);
        int n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 50);
        if (!rvalid) chk("r_timeout", rvalid, 1'b1);
        d = rdata;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        fork
            aw_send(a);
            w_send(d, s);
        join
        wait_b();
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        ar_send(a);
        r_get(d);
    endtask

    logic [31:0] d;
    int p0 [4];
    int b0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; arvalid = 0;
        wdata = 0; wstrb = 0; bready = 1; rready = 1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #1;
        chk("rst_awready", awready, 1'b1);
        chk("rst_wready", wready, 1'b1);
        chk("rst_arready", arready, 1'b1);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_regs", reg_out, 128'h0);

        // Sequential writes then reads
        p0 = pcnt;
        for (int i = 0; i < 4; i++) wr(4'(4 * i), 32'(i + 1), 4'hF);
        chk("seq_reg_out", reg_out, {32'd4, 32'd3, 32'd2, 32'd1});
        for (int i = 0; i < 4; i++) chk("seq_pulses", pcnt[i] - p0[i], 1);
        for (int i = 0; i < 4; i++) begin
            rd(4'(4 * i + 1), d);
            chk("seq_rdata", d, 32'(i + 1));
        end

        // W three cycles ahead of AW
        fork
            w_send(32'hDEADBEEF, 4'hF);
        join_none
        repeat (3) @(negedge clk);
        chk("wfirst_wready", wready, 1'b0);
        @(posedge clk); #1;
        aw_send(4'h8);
        @(negedge clk);
        chk("wfirst_b_early", bvalid, 1'b0);
        @(negedge clk);
        chk("wfirst_b_lat", bvalid, 1'b1);
        @(posedge clk); #1;
        chk("wfirst_reg2", reg_out[95:64], 32'hDEADBEEF);

        // Byte-strobe merge
        wr(4'h4, 32'h11223344, 4'hF);
        wr(4'h6, 32'hAABBCCDD, 4'b0101);
        chk("strb_reg1", reg_out[63:32], 32'h11BB33DD);
        rd(4'h4, d);
        chk("strb_rd", d, 32'h11BB33DD);

        // WSTRB=0 still commits and pulses
        p0 = pcnt;
        wr(4'h0, 32'hFFFFFFFF, 4'h0);
        chk("strb0_reg0", reg_out[31:0], 32'd1);
        chk("strb0_pulse", pcnt[0] - p0[0], 1);

        // B stall with a second write queued behind it
        b0 = brise;
        bready = 0;
        fork
            aw_send(4'h0);
            w_send(32'hA1A1A1A1, 4'hF);
        join
        wait_b();
        fork
            aw_send(4'h0);
            w_send(32'hB2B2B2B2, 4'hF);
        join
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bstall_awready", awready, 1'b0);
            chk("bstall_wready", wready, 1'b0);
            chk("bstall_bvalid", bvalid, 1'b1);
            chk("bstall_reg0", reg_out[31:0], 32'hA1A1A1A1);
        end
        @(posedge clk); #1;
        bready = 1;
        @(posedge clk); #1;
        wait_b();
        chk("bstall_reg0_new", reg_out[31:0], 32'hB2B2B2B2);
        chk("bstall_brise", brise - b0, 2);

        // R stall
        rready = 0;
        ar_send(4'h8);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstall_rvalid", rvalid, 1'b1);
            chk("rstall_rdata", rdata, 32'hDEADBEEF);
            chk("rstall_arready", arready, 1'b0);
        end
        araddr = 4'h4; arvalid = 1;
        @(negedge clk);
        chk("rstall_ar_blocked", arready, 1'b0);
        rready = 1;
        ar_send(4'h4);
        r_get(d);
        chk("rstall_next", d, 32'h11BB33DD);

        // Reset with AW captured, W never sent
        p0 = pcnt;
        aw_send(4'hC);
        @(negedge clk);
        chk("mid_awready", awready, 1'b0);
        @(posedge clk); #2;
        rst_n = 0;
        @(posedge clk); #2;
        rst_n = 1;
        @(negedge clk);
        chk("mid_regs", reg_out, 128'h0);
        chk("mid_bvalid", bvalid, 1'b0);
        @(posedge clk); #1;
        wr(4'hC, 32'h55AA55AA, 4'hF);
        chk("mid_reg3", reg_out[127:96], 32'h55AA55AA);
        chk("mid_pulse3", pcnt[3] - p0[3], 1);
        rd(4'hC, d);
        chk("mid_rd3", d, 32'h55AA55AA);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/efpga_axil_regs.md
Name: efpga_axil_regs

Overview:
AXI4-Lite slave register bank for eFPGA Core1. It sits directly downstream of the PS/VIP AXI4-Lite master port S00_AXI and provides four 32-bit read/write control registers. Register contents and per-register write pulses drive the eFPGA fabric. Write and read paths are independent; each path has at most one outstanding transaction.

Parameters:
DATA_WIDTH, 32, AXI data width; only 32 is supported.
ADDR_WIDTH, 4, AXI address width; bits [3:2] select the register, bits [1:0] are ignored.
NUM_REGS, 4, register count; fixed by ADDR_WIDTH.

Ports:
ACLK  in  1  clock; all logic is rising-edge.
ARESETN  in  1  asynchronous, active-low reset.
S_AXI_AWADDR  in  ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte strobes.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response; always 2'b00.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
reg_out  out  4*32  register contents; reg n occupies [32n+31:32n].
wr_pulse  out  4  one-cycle strobe on the commit of a write to reg n.

Behaviour:
- Reset (ARESETN=0, asynchronous): all registers 0. AWREADY=WREADY=1 one cycle after deassertion; BVALID=RVALID=0; RDATA=0; wr_pulse=0; hold flags cleared. ARREADY=1 after deassertion.
- Reset mid-transaction: the in-flight transaction is dropped and no partial register update occurs.
- Write path: AW and W are captured independently into one-entry holding registers (aw_full, w_full).
  - AWREADY = !aw_full; WREADY = !w_full. Either channel may arrive first or both in the same cycle.
  - Commit occurs on the first edge where aw_full && w_full && !BVALID. On that edge:
    - reg[AWADDR[3:2]] bytes with WSTRB=1 are updated; bytes with WSTRB=0 are kept.
    - BVALID is set, both hold flags are cleared, and wr_pulse[idx] is high for exactly the following cycle.
  - Latency: an AW+W handshake at edge k gives BVALID and an updated reg_out after edge k+1.
  - BVALID clears on the BVALID&&BREADY edge.
  - While BVALID is pending, a new AW/W may be captured, but commit waits for B to be accepted.
  - WSTRB=0: commit and BVALID still occur, register is unchanged, wr_pulse still fires.
- Read path: ARREADY = !RVALID.
  - On an AR handshake edge, RDATA <= reg[ARADDR[3:2]] and RVALID <= 1.
  - RDATA and RVALID hold until RVALID&&RREADY; on that edge RVALID=0.
- Simultaneous events: an AR handshake on the same edge as a write commit to the same register returns the old value. Read and write paths never stall each other.
- Address bits [1:0] are ignored. There is no decode error; all addresses respond OKAY.

Decomposition:
- Package efpga_axil_pkg:
  - RESP_OKAY = 2'b00
  - REG_IDX_W = 2
  - NUM_REGS = 4
  - typedef reg_idx_t (logic [1:0])
  - helper function for byte-strobe merge
- Single module; no sub-module is warranted. Write-commit and read-response logic are separate always blocks.

Test Plan:
- Sequential writes 0x00..0x0C with data 1,2,3,4 and WSTRB=F, then reads at the same addresses -> RDATA 1,2,3,4; BRESP=RRESP=OKAY; reg_out = {4,3,2,1}; wr_pulse fires once per write.
- W presented 3 cycles before AW (addr 0x8, data 0xDEADBEEF) -> WREADY drops after capture; BVALID one edge after the AW handshake; reg2=0xDEADBEEF.
- reg1=0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 -> reg1=0x11BB33DD.
- BREADY held low for 5 cycles, second write issued meanwhile -> second AW/W captured, AWREADY/WREADY then low, second commit occurs only after the first B handshake; two BVALID pulses in order.
- RREADY held low for 4 cycles -> RDATA stable, ARREADY=0 throughout; a new AR is accepted only after the R handshake.
- ARESETN asserted for 1 cycle while a write to reg3 is pending with AW captured and W not yet sent -> after reset, all regs 0, BVALID=0, and a subsequent full write to reg3 completes normally.
